// File: rtl/regfile_dumper_pkg.sv
// Shared constants and FSM state type for the register-bank debug dumper.
package regfile_dumper_pkg;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_dumper_csum_acc.sv
// XOR accumulator folding each streamed register word into a running checksum.
// Present only when DUMP_CHECKSUM_EN is defined.
`ifdef DUMP_CHECKSUM_EN
module dump_csum_acc
    import regfile_dumper_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] acc_o
);

    logic [DW-1:0] acc_q;

    // Clear has priority so a new dump never inherits the previous checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ d_i;
        end
    end

    assign acc_o = acc_q;

endmodule
`endif

// File: rtl/regfile_dumper.sv
// Debug reader for the 32x32 register bank: on start, walks registers
// 0..NREGS-1 through the spare async read port and streams each word out
// over valid/ready. Never writes the bank.
// Optional: DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; rf_ra parked at 0
// ST_FETCH | rf_ra = idx; capture rf_rd into the output beat
// ST_SEND  | register beat valid; held until out_ready
// ST_CSUM  | checksum beat valid; held until out_ready
// ST_DONE  | one-cycle done pulse, back to idle
module regfile_dumper
    import regfile_dumper_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          out_csum,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e        state_q;
    logic [AW-1:0] idx_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [AW-1:0] out_addr_q;
    logic          out_last_q;
    logic          out_csum_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] csum_d;
    logic          csum_en;

`ifdef DUMP_CHECKSUM_EN
    logic [DW-1:0] acc;

    dump_csum_acc u_csum_acc (
        .clk   (clk),
        .rst_n (reset),
        .clr_i ((state_q == ST_IDLE) && start),
        .en_i  ((state_q == ST_SEND) && out_valid_q && out_ready),
        .d_i   (out_data_q),
        .acc_o (acc)
    );

    // The checksum beat is loaded on the same edge the last word is folded in,
    // so it has to include that word explicitly.
    assign csum_d  = acc ^ out_data_q;
    assign csum_en = 1'b1;
`else
    assign csum_d  = '0;
    assign csum_en = 1'b0;
`endif

    // Dump sequencer: index walk, beat capture and handshake, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_csum_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    out_data_q  <= rf_rd;
                    out_addr_q  <= idx_q;
                    out_last_q  <= (idx_q == LAST_IDX) && !csum_en;
                    out_csum_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q       <= idx_q + 1'b1;
                            out_valid_q <= 1'b0;
                            state_q     <= ST_FETCH;
                        end else if (csum_en) begin
                            out_data_q <= csum_d;
                            out_addr_q <= '0;
                            out_csum_q <= 1'b1;
                            out_last_q <= 1'b1;
                            state_q    <= ST_CSUM;
                        end else begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_CSUM: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        out_csum_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rf_ra     = (state_q == ST_IDLE) ? '0 : idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign out_csum  = out_csum_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
